// File: rtl/stream_demux_1to2_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer: datapath width and FSM encoding.
package stream_demux_1to2_pkg;

  localparam int INTERNAL_BITS = 32;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

endpackage

// File: rtl/stream_demux_1to2_out_slice.sv
// One-entry registered output slice; valid and data are flop-driven toward the consumer.
module stream_demux_1to2_out_slice #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  output logic [DATA_W-1:0] dout,
  input  logic              ready,
  output logic              full
);

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;

  // stage p0: load has priority over drain so a simultaneous load/drain keeps the slot full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      if (load) begin
        vld_p0  <= 1'b1;
        data_p0 <= din;
      end else if (vld_p0 && ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign valid = vld_p0;
  assign dout  = data_p0;
  assign full  = vld_p0;

endmodule

// File: rtl/stream_demux_1to2.sv
// 1-to-2 valid/ready demultiplexer; the target output is chosen once per burst of cfg_len+1 beats.
module stream_demux_1to2
  import stream_demux_1to2_pkg::*;
#(
  parameter int DATA_W  = INTERNAL_BITS,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_sel,
  input  logic [BURST_W-1:0] cfg_len,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out0_valid,
  output logic [DATA_W-1:0]  out0_data,
  input  logic               out0_ready,
  output logic               out1_valid,
  output logic [DATA_W-1:0]  out1_data,
  input  logic               out1_ready,
  output logic               busy,
  output logic               burst_done
);

  logic               state;
  logic [BURST_W-1:0] cnt;
  logic [BURST_W-1:0] len_q;
  logic               sel_q;
  logic               done_p0;

  logic eff_sel;
  logic full0;
  logic full1;
  logic sel_full;
  logic sel_ready;
  logic accept;
  logic last_beat;
  logic load0;
  logic load1;

  // cfg is only honoured while no burst is open; mid-burst the latched target wins
  assign eff_sel   = (state == ST_IDLE) ? cfg_sel : sel_q;
  assign sel_full  = eff_sel ? full1 : full0;
  assign sel_ready = eff_sel ? out1_ready : out0_ready;
  assign in_ready  = rst_n & (~sel_full | sel_ready);
  assign accept    = in_valid & in_ready;
  assign last_beat = (state == ST_IDLE) ? (cfg_len == '0) : (cnt == len_q);
  assign load0     = accept & ~eff_sel;
  assign load1     = accept &  eff_sel;

  // stage p0: burst control and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sel_q   <= 1'b0;
      len_q   <= '0;
      done_p0 <= 1'b0;
    end else begin
      done_p0 <= accept & last_beat;
      if (accept) begin
        if (state == ST_IDLE) begin
          sel_q <= cfg_sel;
          len_q <= cfg_len;
          if (cfg_len != '0) begin
            cnt   <= BURST_W'(1);
            state <= ST_BURST;
          end
        end else begin
          if (cnt == len_q) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + BURST_W'(1);
          end
        end
      end
    end
  end

  assign busy       = (state == ST_BURST);
  assign burst_done = done_p0;

  stream_demux_1to2_out_slice #(.DATA_W(DATA_W)) u_slice0 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load0),
    .din   (in_data),
    .valid (out0_valid),
    .dout  (out0_data),
    .ready (out0_ready),
    .full  (full0)
  );

  stream_demux_1to2_out_slice #(.DATA_W(DATA_W)) u_slice1 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load1),
    .din   (in_data),
    .valid (out1_valid),
    .dout  (out1_data),
    .ready (out1_ready),
    .full  (full1)
  );

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed table-driven bench for stream_demux_1to2 plus hand-written reset and abort sequences.
module tb_stream_demux_1to2;

  logic        clk;
  logic        rst_n;
  logic        cfg_sel;
  logic [7:0]  cfg_len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out0_valid;
  logic [31:0] out0_data;
  logic        out0_ready;
  logic        out1_valid;
  logic [31:0] out1_data;
  logic        out1_ready;
  logic        busy;
  logic        burst_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        sel;
    logic [7:0]  len;
    logic        iv;
    logic [31:0] d;
    logic        r0;
    logic        r1;
    logic        irdy;
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1;
    logic        bsy;
    logic        done;
  } vec_t;

  vec_t vq[$];

  stream_demux_1to2 #(.DATA_W(32), .BURST_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_sel    (cfg_sel),
    .cfg_len    (cfg_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_ready (out0_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready),
    .busy       (busy),
    .burst_done (burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic sel, logic [7:0] len, logic iv, logic [31:0] d,
                              logic r0, logic r1, logic irdy, logic v0, logic [31:0] d0,
                              logic v1, logic [31:0] d1, logic bsy, logic done);
    vec_t v;
    v.sel = sel; v.len = len; v.iv = iv; v.d = d; v.r0 = r0; v.r1 = r1;
    v.irdy = irdy; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.bsy = bsy; v.done = done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // inputs change on the falling edge; registered outputs are sampled 1ns after the rising edge
  task automatic apply(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    @(negedge clk);
    cfg_sel = v.sel; cfg_len = v.len; in_valid = v.iv; in_data = v.d;
    out0_ready = v.r0; out1_ready = v.r1;
    #1;
    chk({t, ".in_ready"}, 32'(in_ready), 32'(v.irdy));
    @(posedge clk);
    #1;
    chk({t, ".out0_valid"}, 32'(out0_valid), 32'(v.v0));
    chk({t, ".out0_data"}, out0_data, v.d0);
    chk({t, ".out1_valid"}, 32'(out1_valid), 32'(v.v1));
    chk({t, ".out1_data"}, out1_data, v.d1);
    chk({t, ".busy"}, 32'(busy), 32'(v.bsy));
    chk({t, ".burst_done"}, 32'(burst_done), 32'(v.done));
  endtask

  initial begin
    //            sel len iv data      r0 r1 irdy v0 d0        v1 d1        bsy done
    // single burst to out0, len=3
    vq.push_back(mk(0, 3, 1, 32'h11, 1, 1, 1, 1, 32'h11, 0, 32'h00, 1, 0));
    vq.push_back(mk(0, 3, 1, 32'h12, 1, 1, 1, 1, 32'h12, 0, 32'h00, 1, 0));
    vq.push_back(mk(0, 3, 1, 32'h13, 1, 1, 1, 1, 32'h13, 0, 32'h00, 1, 0));
    vq.push_back(mk(0, 3, 1, 32'h14, 1, 1, 1, 1, 32'h14, 0, 32'h00, 0, 1));
    vq.push_back(mk(0, 3, 0, 32'h00, 1, 1, 1, 0, 32'h14, 0, 32'h00, 0, 0));
    // back-to-back: A (sel=1,len=1) then B (sel=0,len=0)
    vq.push_back(mk(1, 1, 1, 32'hA0, 1, 1, 1, 0, 32'h14, 1, 32'hA0, 1, 0));
    vq.push_back(mk(1, 1, 1, 32'hA1, 1, 1, 1, 0, 32'h14, 1, 32'hA1, 0, 1));
    vq.push_back(mk(0, 0, 1, 32'hB0, 1, 1, 1, 1, 32'hB0, 0, 32'hA1, 0, 1));
    vq.push_back(mk(0, 0, 0, 32'h00, 1, 1, 1, 0, 32'hB0, 0, 32'hA1, 0, 0));
    // backpressure on out0: sel=0 len=2, five stalled cycles
    vq.push_back(mk(0, 2, 1, 32'hC0, 0, 1, 1, 1, 32'hC0, 0, 32'hA1, 1, 0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0, 2, 1, 32'hC1, 0, 1, 0, 1, 32'hC0, 0, 32'hA1, 1, 0));
    vq.push_back(mk(0, 2, 1, 32'hC1, 1, 1, 1, 1, 32'hC1, 0, 32'hA1, 1, 0));
    vq.push_back(mk(0, 2, 1, 32'hC2, 1, 1, 1, 1, 32'hC2, 0, 32'hA1, 0, 1));
    vq.push_back(mk(0, 2, 0, 32'h00, 1, 1, 1, 0, 32'hC2, 0, 32'hA1, 0, 0));
    // cfg changes mid-burst are ignored: sel=1 len=3
    vq.push_back(mk(1, 3, 1, 32'hD0, 1, 1, 1, 0, 32'hC2, 1, 32'hD0, 1, 0));
    vq.push_back(mk(0, 0, 1, 32'hD1, 1, 1, 1, 0, 32'hC2, 1, 32'hD1, 1, 0));
    vq.push_back(mk(0, 0, 1, 32'hD2, 1, 1, 1, 0, 32'hC2, 1, 32'hD2, 1, 0));
    vq.push_back(mk(0, 0, 1, 32'hD3, 1, 1, 1, 0, 32'hC2, 1, 32'hD3, 0, 1));
    vq.push_back(mk(0, 0, 0, 32'h00, 1, 1, 1, 0, 32'hC2, 0, 32'hD3, 0, 0));
    // new burst targets a full, stalled out1
    vq.push_back(mk(1, 0, 1, 32'hE0, 1, 0, 1, 0, 32'hC2, 1, 32'hE0, 0, 1));
    vq.push_back(mk(1, 0, 1, 32'hE1, 1, 0, 0, 0, 32'hC2, 1, 32'hE0, 0, 0));
    vq.push_back(mk(1, 0, 1, 32'hE1, 1, 1, 1, 0, 32'hC2, 1, 32'hE1, 0, 1));
    vq.push_back(mk(1, 0, 0, 32'h00, 1, 1, 1, 0, 32'hC2, 0, 32'hE1, 0, 0));

    // reset held with in_valid high
    rst_n = 1'b1; cfg_sel = 1'b0; cfg_len = 8'd0; in_valid = 1'b0; in_data = 32'h0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    #2 rst_n = 1'b0;
    in_valid = 1'b1; in_data = 32'h5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'h0);
    chk("rst.out0_valid", 32'(out0_valid), 32'h0);
    chk("rst.out0_data", out0_data, 32'h0);
    chk("rst.out1_valid", 32'(out1_valid), 32'h0);
    chk("rst.out1_data", out1_data, 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.burst_done", 32'(burst_done), 32'h0);
    rst_n = 1'b1; in_valid = 1'b0;

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // abort: reset asserted mid-cycle after beat 2 of a len=7 burst
    apply(mk(0, 7, 1, 32'hF0, 1, 1, 1, 1, 32'hF0, 0, 32'hE1, 1, 0), 100);
    apply(mk(0, 7, 1, 32'hF1, 1, 1, 1, 1, 32'hF1, 0, 32'hE1, 1, 0), 101);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; in_data = 32'hF2;
    #1;
    chk("abort.out0_valid", 32'(out0_valid), 32'h0);
    chk("abort.out0_data", out0_data, 32'h0);
    chk("abort.out1_data", out1_data, 32'h0);
    chk("abort.busy", 32'(busy), 32'h0);
    chk("abort.in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("abort.burst_done", 32'(burst_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    apply(mk(0, 1, 1, 32'h61, 1, 1, 1, 1, 32'h61, 0, 32'h00, 1, 0), 102);
    apply(mk(0, 1, 1, 32'h62, 1, 1, 1, 1, 32'h62, 0, 32'h00, 0, 1), 103);
    apply(mk(0, 1, 0, 32'h00, 1, 1, 1, 0, 32'h62, 0, 32'h00, 0, 0), 104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
